// File: rtl/dec_entry.sv
// Signed decimal number entry: turns debounced keypad pulses into an 8-bit two's-complement
// value, shows it live, and hands committed values downstream over a valid/ack handshake.
module dec_entry #(
  parameter int unsigned MAX_DIGITS     = 3,
  parameter int unsigned TIMEOUT_CLOCKS = 250000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] DigitIn,
  input  logic       DigitPress,
  input  logic       SignPress,
  input  logic       EnterPress,
  input  logic       ClearPress,
  input  logic       DataAck,
  output logic [7:0] EntryValue,
  output logic [1:0] EntryCount,
  output logic       Error,
  output logic [7:0] DataOut,
  output logic       DataValid
);

  localparam bit          TimeoutEn = (TIMEOUT_CLOCKS != 0);
  localparam int unsigned TimerW    = TimeoutEn ? $clog2(64'(TIMEOUT_CLOCKS) + 64'd1) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CLOCKS - 1);
  localparam logic [1:0]        MaxCount  = 2'(MAX_DIGITS);

  typedef enum logic [1:0] {StEmpty, StEntry, StPending, StError} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mag_q, mag_d;
  logic              sign_q, sign_d;
  logic [1:0]        count_q, count_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [7:0]        entry_value_q, entry_value_d;
  logic [1:0]        entry_count_q, entry_count_d;
  logic              error_q, error_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;

  logic [10:0] next_mag;
  logic [10:0] limit;
  logic        digit_ok;
  logic        timeout;
  logic        accepted;
  logic [7:0]  cur_signed;
  logic [7:0]  next_signed;

  always_comb begin
    state_d      = state_q;
    mag_d        = mag_q;
    sign_d       = sign_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    accepted     = 1'b0;

    // Full 11-bit product so an overflowing entry is caught rather than wrapped.
    next_mag   = {3'b000, mag_q} * 11'd10 + {7'b0000000, DigitIn};
    limit      = sign_q ? 11'd128 : 11'd127;
    digit_ok   = (DigitIn <= 4'd9) && (count_q < MaxCount) && (next_mag <= limit);
    timeout    = TimeoutEn && (state_q inside {StEntry, StError}) && (timer_q == TimerLast);
    cur_signed = sign_q ? (~mag_q + 8'd1) : mag_q;

    unique case (state_q)
      StEmpty: begin
        if (!ClearPress && !EnterPress) begin
          if (SignPress) begin
            sign_d   = 1'b1;
            state_d  = StEntry;
            accepted = 1'b1;
          end else if (DigitPress) begin
            accepted = 1'b1;
            if (digit_ok) begin
              mag_d   = next_mag[7:0];
              count_d = count_q + 2'd1;
              state_d = StEntry;
            end else begin
              state_d = StError;
            end
          end
        end
      end
      StEntry: begin
        if (timeout || ClearPress) begin
          state_d  = StEmpty;
          accepted = ClearPress;
        end else if (EnterPress) begin
          data_out_d   = cur_signed;
          data_valid_d = 1'b1;
          state_d      = StPending;
          accepted     = 1'b1;
        end else if (SignPress) begin
          accepted = 1'b1;
          // -128 has no positive counterpart in eight bits.
          if (sign_q && (mag_q == 8'd128)) begin
            state_d = StError;
          end else begin
            sign_d = ~sign_q;
          end
        end else if (DigitPress) begin
          accepted = 1'b1;
          if (digit_ok) begin
            mag_d   = next_mag[7:0];
            count_d = count_q + 2'd1;
          end else begin
            state_d = StError;
          end
        end
      end
      StPending: begin
        if (DataAck) begin
          data_valid_d = 1'b0;
          state_d      = StEmpty;
        end
      end
      StError: begin
        if (timeout || ClearPress) begin
          state_d  = StEmpty;
          accepted = ClearPress;
        end
      end
      default: state_d = StEmpty;
    endcase

    if (state_d != StEntry) begin
      mag_d   = 8'd0;
      sign_d  = 1'b0;
      count_d = 2'd0;
    end

    if (!TimeoutEn || accepted || (state_d != state_q) ||
        !(state_d inside {StEntry, StError})) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TimerW'(1);
    end

    next_signed   = sign_d ? (~mag_d + 8'd1) : mag_d;
    entry_value_d = (state_d == StEntry) ? next_signed : 8'd0;
    entry_count_d = (state_d == StEntry) ? count_d : 2'd0;
    error_d       = (state_d == StError);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= StEmpty;
      mag_q         <= 8'd0;
      sign_q        <= 1'b0;
      count_q       <= 2'd0;
      timer_q       <= '0;
      entry_value_q <= 8'd0;
      entry_count_q <= 2'd0;
      error_q       <= 1'b0;
      data_out_q    <= 8'd0;
      data_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      mag_q         <= mag_d;
      sign_q        <= sign_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      entry_value_q <= entry_value_d;
      entry_count_q <= entry_count_d;
      error_q       <= error_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
    end
  end

  assign EntryValue = entry_value_q;
  assign EntryCount = entry_count_q;
  assign Error      = error_q;
  assign DataOut    = data_out_q;
  assign DataValid  = data_valid_q;

endmodule

// File: tb/tb_dec_entry.sv
// Scoreboard bench for dec_entry: each stimulus cycle pushes the expected outputs, which are
// popped and compared once the DUT has registered the press.
module tb_dec_entry;

  localparam logic [4:0] PNone = 5'b00000;
  localparam logic [4:0] PDig  = 5'b00001;
  localparam logic [4:0] PSgn  = 5'b00010;
  localparam logic [4:0] PEnt  = 5'b00100;
  localparam logic [4:0] PClr  = 5'b01000;
  localparam logic [4:0] PAck  = 5'b10000;

  typedef struct {
    logic [7:0] ev;
    logic [1:0] ec;
    logic       err;
    logic [7:0] dout;
    logic       dv;
  } exp_t;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] DigitIn = 4'd0;
  logic       DigitPress = 1'b0;
  logic       SignPress = 1'b0;
  logic       EnterPress = 1'b0;
  logic       ClearPress = 1'b0;
  logic       DataAck = 1'b0;
  logic [7:0] EntryValue;
  logic [1:0] EntryCount;
  logic       Error;
  logic [7:0] DataOut;
  logic       DataValid;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_dout = 8'h00;
  logic       exp_dv = 1'b0;

  dec_entry #(
    .MAX_DIGITS    (3),
    .TIMEOUT_CLOCKS(16)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .DigitIn   (DigitIn),
    .DigitPress(DigitPress),
    .SignPress (SignPress),
    .EnterPress(EnterPress),
    .ClearPress(ClearPress),
    .DataAck   (DataAck),
    .EntryValue(EntryValue),
    .EntryCount(EntryCount),
    .Error     (Error),
    .DataOut   (DataOut),
    .DataValid (DataValid)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; expected outputs for the following edge go through the scoreboard.
  task automatic step(input string tag, input logic [4:0] p, input logic [3:0] d,
                      input logic [7:0] ev, input logic [1:0] ec, input logic err);
    exp_t e;
    DigitIn    = d;
    DigitPress = p[0];
    SignPress  = p[1];
    EnterPress = p[2];
    ClearPress = p[3];
    DataAck    = p[4];
    e.ev = ev; e.ec = ec; e.err = err; e.dout = exp_dout; e.dv = exp_dv;
    sb_q.push_back(e);
    @(posedge Clock);
    #1;
    {DataAck, ClearPress, EnterPress, SignPress, DigitPress} = 5'b00000;
    DigitIn = 4'd0;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 8'd1, 8'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_ev"}, EntryValue, e.ev);
      check({tag, "_ec"}, {6'd0, EntryCount}, {6'd0, e.ec});
      check({tag, "_err"}, {7'd0, Error}, {7'd0, e.err});
      check({tag, "_dout"}, DataOut, e.dout);
      check({tag, "_dv"}, {7'd0, DataValid}, {7'd0, e.dv});
    end
  endtask

  initial begin
    #12;
    check("rst_ev", EntryValue, 8'h00);
    check("rst_ec", {6'd0, EntryCount}, 8'h00);
    check("rst_err", {7'd0, Error}, 8'h00);
    check("rst_dout", DataOut, 8'h00);
    check("rst_dv", {7'd0, DataValid}, 8'h00);
    Reset = 1'b0;
    @(posedge Clock);
    #1;

    // Positive entry and handshake
    step("p1", PDig, 4'd1, 8'h01, 2'd1, 1'b0);
    step("p2", PDig, 4'd2, 8'h0C, 2'd2, 1'b0);
    step("p7", PDig, 4'd7, 8'h7F, 2'd3, 1'b0);
    exp_dout = 8'h7F; exp_dv = 1'b1;
    step("pent", PEnt, 4'd0, 8'h00, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++) step("phold", PNone, 4'd0, 8'h00, 2'd0, 1'b0);
    exp_dv = 1'b0;
    step("pack", PAck, 4'd0, 8'h00, 2'd0, 1'b0);
    step("ackidle", PAck, 4'd0, 8'h00, 2'd0, 1'b0);

    // Negative entry down to -128
    step("nsgn", PSgn, 4'd0, 8'h00, 2'd0, 1'b0);
    step("n1", PDig, 4'd1, 8'hFF, 2'd1, 1'b0);
    step("n2", PDig, 4'd2, 8'hF4, 2'd2, 1'b0);
    step("n8", PDig, 4'd8, 8'h80, 2'd3, 1'b0);
    exp_dout = 8'h80; exp_dv = 1'b1;
    step("nent", PEnt, 4'd0, 8'h00, 2'd0, 1'b0);
    exp_dv = 1'b0;
    step("nack", PAck, 4'd0, 8'h00, 2'd0, 1'b0);

    // Flipping -128 positive is an error
    step("fsgn", PSgn, 4'd0, 8'h00, 2'd0, 1'b0);
    step("f1", PDig, 4'd1, 8'hFF, 2'd1, 1'b0);
    step("f2", PDig, 4'd2, 8'hF4, 2'd2, 1'b0);
    step("f8", PDig, 4'd8, 8'h80, 2'd3, 1'b0);
    step("fsgn2", PSgn, 4'd0, 8'h00, 2'd0, 1'b1);
    step("fclr", PClr, 4'd0, 8'h00, 2'd0, 1'b0);

    // Range, digit-value and digit-count errors
    step("o1", PDig, 4'd1, 8'h01, 2'd1, 1'b0);
    step("o2", PDig, 4'd2, 8'h0C, 2'd2, 1'b0);
    step("o8", PDig, 4'd8, 8'h00, 2'd0, 1'b1);
    step("oclr", PClr, 4'd0, 8'h00, 2'd0, 1'b0);
    step("hexa", PDig, 4'hA, 8'h00, 2'd0, 1'b1);
    step("hclr", PClr, 4'd0, 8'h00, 2'd0, 1'b0);
    step("c0a", PDig, 4'd0, 8'h00, 2'd1, 1'b0);
    step("c0b", PDig, 4'd0, 8'h00, 2'd2, 1'b0);
    step("c1", PDig, 4'd1, 8'h01, 2'd3, 1'b0);
    step("c2", PDig, 4'd2, 8'h00, 2'd0, 1'b1);
    step("eent", PEnt, 4'd0, 8'h00, 2'd0, 1'b1);
    step("edig", PDig, 4'd3, 8'h00, 2'd0, 1'b1);
    step("eclr", PClr, 4'd0, 8'h00, 2'd0, 1'b0);

    // Same-cycle priority and presses while pending
    step("q3", PDig, 4'd3, 8'h03, 2'd1, 1'b0);
    step("qclrdig", PClr | PDig, 4'd5, 8'h00, 2'd0, 1'b0);
    step("q4", PDig, 4'd4, 8'h04, 2'd1, 1'b0);
    exp_dout = 8'h04; exp_dv = 1'b1;
    step("qentdig", PEnt | PDig, 4'd9, 8'h00, 2'd0, 1'b0);
    step("wdig", PDig, 4'd5, 8'h00, 2'd0, 1'b0);
    step("wsgn", PSgn, 4'd0, 8'h00, 2'd0, 1'b0);
    step("went", PEnt, 4'd0, 8'h00, 2'd0, 1'b0);
    step("wclr", PClr, 4'd0, 8'h00, 2'd0, 1'b0);
    exp_dv = 1'b0;
    step("wack", PAck, 4'd0, 8'h00, 2'd0, 1'b0);

    // Idle timeout after 16 clocks, restarted by a press
    step("t5", PDig, 4'd5, 8'h05, 2'd1, 1'b0);
    for (int i = 0; i < 15; i++) step("tidle", PNone, 4'd0, 8'h05, 2'd1, 1'b0);
    step("tout", PNone, 4'd0, 8'h00, 2'd0, 1'b0);
    step("r5", PDig, 4'd5, 8'h05, 2'd1, 1'b0);
    for (int i = 0; i < 9; i++) step("ridle", PNone, 4'd0, 8'h05, 2'd1, 1'b0);
    step("rpress", PDig, 4'd1, 8'h33, 2'd2, 1'b0);
    for (int i = 0; i < 15; i++) step("ridle2", PNone, 4'd0, 8'h33, 2'd2, 1'b0);
    step("rout", PNone, 4'd0, 8'h00, 2'd0, 1'b0);

    // Asynchronous reset between edges while pending
    step("a6", PDig, 4'd6, 8'h06, 2'd1, 1'b0);
    exp_dout = 8'h06; exp_dv = 1'b1;
    step("aent", PEnt, 4'd0, 8'h00, 2'd0, 1'b0);
    #3;
    Reset = 1'b1;
    #1;
    check("arst_dv", {7'd0, DataValid}, 8'h00);
    check("arst_dout", DataOut, 8'h00);
    check("arst_err", {7'd0, Error}, 8'h00);
    check("arst_ev", EntryValue, 8'h00);
    #1;
    Reset = 1'b0;
    exp_dout = 8'h00; exp_dv = 1'b0;
    step("b1", PDig, 4'd1, 8'h01, 2'd1, 1'b0);
    step("b2", PSgn, 4'd0, 8'hFF, 2'd1, 1'b0);
    exp_dout = 8'hFF; exp_dv = 1'b1;
    step("bent", PEnt, 4'd0, 8'h00, 2'd0, 1'b0);
    exp_dv = 1'b0;
    step("back", PAck, 4'd0, 8'h00, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_entry.md
Name: dec_entry

Overview:
- Signed decimal number-entry block. It is the input-side counterpart of the signed decimal display path: the display path turns an 8-bit two's-complement value into decimal digits, and this block turns operator decimal keystrokes back into an 8-bit two's-complement value.
- Sits after the synchroniser/debounce/falling-edge chain. Consumes single-cycle press pulses plus a 4-bit digit from switches.
- Presents a live entry value for on-board display.
- Hands committed values downstream over a valid/ack handshake.

Parameters:
- MAX_DIGITS, 3, maximum decimal digits accepted per entry, leading zeros included. Legal range 1..3.
- TIMEOUT_CLOCKS, 250000000, idle clocks before an unfinished entry is discarded. 0 disables the timeout.

Ports:
- Clock  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- DigitIn  input  4  digit value from switches, sampled in the cycle DigitPress is high.
- DigitPress  input  1  single-cycle pulse: append DigitIn.
- SignPress  input  1  single-cycle pulse: toggle the entry sign.
- EnterPress  input  1  single-cycle pulse: commit the entry.
- ClearPress  input  1  single-cycle pulse: discard the entry or clear an error.
- DataAck  input  1  downstream has consumed DataOut.
- EntryValue  output  8  signed live entry value (sign ? -mag : mag). Forced to 0 outside ENTRY.
- EntryCount  output  2  number of digits accepted so far.
- Error  output  1  high while in ERROR.
- DataOut  output  8  last committed signed value. Holds until the next commit.
- DataValid  output  1  committed value pending, held until acked.

Behaviour:
- All outputs are registered and update one clock after the press cycle.
- Reset (async): state=EMPTY, mag=0, sign=0, count=0, timer=0, and all outputs=0. Reset mid-PENDING drops DataValid immediately.
- Press priority within one cycle is Clear > Enter > Sign > Digit. At most one action is taken per cycle; lower-priority pulses in that cycle are discarded.
- Internal state: mag (8-bit unsigned), sign, count.
- limit = sign ? 128 : 127.
- Digit acceptance:
  - next = mag*10 + DigitIn, computed at 11 bits with no truncation.
  - DigitIn > 9 -> ERROR.
  - count == MAX_DIGITS -> ERROR.
  - next > limit -> ERROR.
  - Otherwise mag=next, count+1.
- States:
  - EMPTY: mag=0, sign=0, count=0.
    - Digit -> apply the digit rule; accepted -> ENTRY.
    - Sign -> sign=1, -> ENTRY with count 0.
    - Enter and Clear are ignored.
  - ENTRY:
    - Digit -> digit rule.
    - Sign -> toggle. Toggling to positive while mag==128 -> ERROR.
    - Clear -> EMPTY.
    - Enter -> DataOut=EntryValue (mag 0 with sign 1 commits 0x00), DataValid=1, entry cleared, -> PENDING.
  - PENDING: DataValid=1, and all presses are ignored.
    - DataAck -> DataValid=0 next cycle, -> EMPTY.
    - DataAck while DataValid=0 has no effect in any state.
  - ERROR: Error=1, EntryValue=0, EntryCount=0.
    - Only Clear exits, -> EMPTY. All other presses are ignored.
- Timeout (TIMEOUT_CLOCKS>0):
  - The timer counts every clock in ENTRY or ERROR and resets to 0 on any accepted press or on state entry.
  - When timer reaches TIMEOUT_CLOCKS-1 -> EMPTY next cycle, same effect as Clear.
  - The timer is held at 0 in EMPTY and PENDING.
  - Timer width is clog2(TIMEOUT_CLOCKS+1).
- DataOut is never altered except by a commit or by Reset.

Test Plan:
- Digit pulses 1,2,7 then Enter -> EntryValue 0x01, 0x0C, 0x7F, EntryCount 1,2,3. Then DataOut=0x7F, DataValid=1, held for 10 cycles with no ack. DataAck -> DataValid=0 next cycle, state EMPTY, EntryValue 0.
- Sign, 1,2,8, Enter -> EntryValue 0xFF, 0xF4, 0x80 and DataOut=0x80. Separately: Sign,1,2,8 then Sign -> Error=1, EntryValue=0. Clear -> Error=0.
- Positive entry 1,2,8 -> Error=1 on the third digit. Digit 0xA from EMPTY -> Error=1. Digits 0,0,1,2 -> Error on the fourth digit. In ERROR, Enter and Digit are ignored; Clear recovers.
- Same-cycle ClearPress+DigitPress(5) in ENTRY with mag 3 -> EMPTY, EntryValue 0. Same-cycle EnterPress+DigitPress(9) with mag 4 -> DataOut=0x04. Presses during PENDING -> no change to DataOut or EntryValue.
- TIMEOUT_CLOCKS=16: Digit 5, then 15 idle cycles -> still EntryValue 5. At the 16th idle cycle -> EntryValue 0, EntryCount 0. A press at idle cycle 10 restarts the count.
- Reset asserted asynchronously mid-PENDING, between clock edges -> DataValid, DataOut, Error and EntryValue all 0 before the next edge. Normal entry works after release.
